// File: rtl/dwconv_tile_fetch.sv
// Tile fetcher for the depthwise 3x3 stage: reads 6x6 int8 maps and 3x3 kernels, emits padded 4x4 tiles.
// Define DWCONV_FETCH_PERF_EN to add the perf_cycles busy-cycle counter output.
module dwconv_tile_fetch #(
    parameter int CH_NUM = 32,
    parameter int FMAP_W = 6
) (
    input  logic         clk,
    input  logic         rst_b,
    input  logic         start,
    output logic         busy,
    output logic         done,
    output logic         fmap_rd_en,
    output logic [7:0]   fmap_rd_addr,
    input  logic [47:0]  fmap_rd_data,
    output logic         w_rd_en,
    output logic [4:0]   w_rd_addr,
    input  logic [71:0]  w_rd_data,
    output logic         en,
    output logic [4:0]   cnt_out,
    output logic [3:0]   pos_out,
    output logic [127:0] input_data,
    output logic [71:0]  select_weight
`ifdef DWCONV_FETCH_PERF_EN
    ,
    output logic [15:0]  perf_cycles
`endif
);

    localparam logic [4:0] LAST_CH  = 5'(CH_NUM - 1);
    localparam logic [3:0] LAST_POS = 4'd8;
    localparam logic [2:0] LAST_ROW = 3'(FMAP_W);

    typedef enum logic [2:0] {
        S_IDLE, S_RD0, S_RD1, S_RD2, S_RD3, S_CAP, S_EMIT, S_DONE
    } state_t;

    state_t        r_state, w_next;
    logic [4:0]    r_ch;
    logic [3:0]    r_pos;
    logic [95:0]   r_tile;
    logic [71:0]   r_wt;
    logic          r_rd_vld;

    logic [1:0]    w_py, w_px, w_k;
    logic          w_rd_phase;
    logic [2:0]    w_pr;
    logic          w_row_hit;
    logic          w_last;
    logic [47:0]   w_cap_row;
    logic [31:0]   w_pick_row;

    always_comb begin
        w_py = 2'd0;
        w_px = 2'd0;
        if (r_pos >= 4'd6) begin
            w_py = 2'd2;
            w_px = 2'(r_pos - 4'd6);
        end else if (r_pos >= 4'd3) begin
            w_py = 2'd1;
            w_px = 2'(r_pos - 4'd3);
        end else begin
            w_px = 2'(r_pos);
        end
    end

    always_comb begin
        w_k        = 2'd0;
        w_rd_phase = 1'b0;
        case (r_state)
            S_RD0: begin w_k = 2'd0; w_rd_phase = 1'b1; end
            S_RD1: begin w_k = 2'd1; w_rd_phase = 1'b1; end
            S_RD2: begin w_k = 2'd2; w_rd_phase = 1'b1; end
            S_RD3: begin w_k = 2'd3; w_rd_phase = 1'b1; end
            default: ;
        endcase
    end

    // Padded rows 0 and 7 are the zero border; only rows 1..6 touch the buffer.
    assign w_pr      = {w_py, 1'b0} + {1'b0, w_k};
    assign w_row_hit = w_rd_phase && (w_pr != 3'd0) && (w_pr <= LAST_ROW);
    assign w_last    = (r_ch == LAST_CH) && (r_pos == LAST_POS);

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next       = r_state;
        busy         = 1'b0;
        done         = 1'b0;
        en           = 1'b0;
        w_rd_en      = 1'b0;
        w_rd_addr    = 5'd0;
        fmap_rd_en   = w_row_hit;
        fmap_rd_addr = w_row_hit ? {r_ch, w_pr - 3'd1} : 8'd0;
        case (r_state)
            S_IDLE: if (start) w_next = S_RD0;
            S_RD0: begin
                busy      = 1'b1;
                w_rd_en   = 1'b1;
                w_rd_addr = r_ch;
                w_next    = S_RD1;
            end
            S_RD1: begin busy = 1'b1; w_next = S_RD2; end
            S_RD2: begin busy = 1'b1; w_next = S_RD3; end
            S_RD3: begin busy = 1'b1; w_next = S_CAP; end
            S_CAP: begin busy = 1'b1; w_next = S_EMIT; end
            S_EMIT: begin
                busy   = 1'b1;
                en     = 1'b1;
                w_next = w_last ? S_DONE : S_RD0;
            end
            S_DONE: begin done = 1'b1; w_next = S_IDLE; end
            default: w_next = S_IDLE;
        endcase
    end

    // A skipped read leaves stale data on the bus, so the row is forced to zero.
    assign w_cap_row = r_rd_vld ? fmap_rd_data : 48'd0;

    function automatic logic [7:0] f_pick(input logic [47:0] row, input logic [2:0] pc);
        case (pc)
            3'd1:    f_pick = row[7:0];
            3'd2:    f_pick = row[15:8];
            3'd3:    f_pick = row[23:16];
            3'd4:    f_pick = row[31:24];
            3'd5:    f_pick = row[39:32];
            3'd6:    f_pick = row[47:40];
            default: f_pick = 8'd0;
        endcase
    endfunction

    genvar gj;
    generate
        for (gj = 0; gj < 4; gj++) begin : g_col
            assign w_pick_row[gj*8 +: 8] = f_pick(w_cap_row, {w_px, 1'b0} + 3'(gj));
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            r_ch          <= 5'd0;
            r_pos         <= 4'd0;
            r_tile        <= 96'd0;
            r_wt          <= 72'd0;
            r_rd_vld      <= 1'b0;
            input_data    <= 128'd0;
            select_weight <= 72'd0;
            cnt_out       <= 5'd0;
            pos_out       <= 4'd0;
        end else begin
            r_rd_vld <= fmap_rd_en;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_ch  <= 5'd0;
                        r_pos <= 4'd0;
                    end
                end
                S_RD1: begin
                    r_tile[31:0] <= w_pick_row;
                    r_wt         <= w_rd_data;
                end
                S_RD2: r_tile[63:32] <= w_pick_row;
                S_RD3: r_tile[95:64] <= w_pick_row;
                S_CAP: begin
                    input_data    <= {w_pick_row, r_tile};
                    select_weight <= r_wt;
                    cnt_out       <= r_ch;
                    pos_out       <= r_pos;
                end
                S_EMIT: begin
                    if (r_ch == LAST_CH) begin
                        r_ch  <= 5'd0;
                        r_pos <= (r_pos == LAST_POS) ? 4'd0 : r_pos + 4'd1;
                    end else begin
                        r_ch <= r_ch + 5'd1;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef DWCONV_FETCH_PERF_EN
    logic [15:0] r_perf;

    // Counts every non-idle state, DONE included, and saturates.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            r_perf <= 16'd0;
        end else if (r_state == S_IDLE) begin
            if (start) r_perf <= 16'd0;
        end else if (r_perf != 16'hFFFF) begin
            r_perf <= r_perf + 16'd1;
        end
    end

    assign perf_cycles = r_perf;
`else
    // Cycle counter compiled out; tile datapath unchanged.
`endif

endmodule

// File: tb/tb_dwconv_tile_fetch.sv
// Directed bench for dwconv_tile_fetch: full-pass monitor, tile element table, restart/reset sequences.
module tb_dwconv_tile_fetch;

    logic         clk = 1'b0;
    logic         rst_b = 1'b0;
    logic         start = 1'b0;
    logic         busy, done, fmap_rd_en, w_rd_en, en;
    logic [7:0]   fmap_rd_addr;
    logic [47:0]  fmap_rd_data = '0;
    logic [4:0]   w_rd_addr, cnt_out;
    logic [71:0]  w_rd_data = '0;
    logic [3:0]   pos_out;
    logic [127:0] input_data;
    logic [71:0]  select_weight;
`ifdef DWCONV_FETCH_PERF_EN
    logic [15:0]  perf_cycles;
`endif

    always #5 clk = ~clk;

    dwconv_tile_fetch dut (
        .clk           (clk),
        .rst_b         (rst_b),
        .start         (start),
        .busy          (busy),
        .done          (done),
        .fmap_rd_en    (fmap_rd_en),
        .fmap_rd_addr  (fmap_rd_addr),
        .fmap_rd_data  (fmap_rd_data),
        .w_rd_en       (w_rd_en),
        .w_rd_addr     (w_rd_addr),
        .w_rd_data     (w_rd_data),
        .en            (en),
        .cnt_out       (cnt_out),
        .pos_out       (pos_out),
        .input_data    (input_data),
        .select_weight (select_weight)
`ifdef DWCONV_FETCH_PERF_EN
        ,
        .perf_cycles   (perf_cycles)
`endif
    );

    // Buffer models: one-cycle read latency, junk when not enabled.
    logic [47:0] fm [256];
    logic [71:0] wt [32];
    always @(posedge clk) begin
        fmap_rd_data <= (fmap_rd_en && fmap_rd_addr[2:0] < 3'd6) ? fm[fmap_rd_addr] : {6{8'hA5}};
        w_rd_data    <= w_rd_en ? wt[w_rd_addr] : {9{8'h5A}};
    end

    int n_checks = 0, n_fail = 0;
    int cyc = 0, start_cyc = 0, last_cyc = 0, done_cyc = 0;
    int n_en = 0, busy_cnt = 0, done_cnt = 0, done_total = 0;
    bit mon_on = 1'b0;
    logic [5:0]   hist = '0;
    logic [5:0]   exp_mask;
    logic [127:0] cap_tile [288];
    logic [71:0]  cap_w [288];

    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) if (done) done_total++;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Per-tile monitor: traversal order, 6-cycle spacing, read-enable pattern over RD0..EMIT.
    always @(negedge clk) begin
        if (mon_on) begin
            hist = {hist[4:0], fmap_rd_en};
            if (busy) busy_cnt++;
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
            end
            if (en) begin
                chk("seq_cnt", cnt_out, n_en % 32);
                chk("seq_pos", pos_out, n_en / 32);
                chk("en_spacing", cyc - last_cyc, 6);
                case ((n_en / 32) / 3)
                    0:       exp_mask = 6'b011100;
                    1:       exp_mask = 6'b111100;
                    default: exp_mask = 6'b111000;
                endcase
                chk("rd_en_pattern", hist, exp_mask);
                if (n_en < 288) begin
                    cap_tile[n_en] = input_data;
                    cap_w[n_en]    = select_weight;
                end
                last_cyc = cyc;
                n_en++;
            end
        end
    end

    task automatic start_monitor();
        n_en = 0; busy_cnt = 0; done_cnt = 0; hist = '0;
        mon_on = 1'b1;
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        start_cyc = cyc;
        last_cyc = cyc;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input string nm);
        int k;
        for (k = 0; k < 2000; k++) begin
            if (done) break;
            @(negedge clk);
        end
        chk(nm, (k < 2000), 1'b1);
    endtask

    task automatic chk_idle_outputs(input string nm);
        chk({nm, "_ctrl"}, {busy, done, en, fmap_rd_en, fmap_rd_addr, w_rd_en, w_rd_addr, cnt_out, pos_out}, 0);
        chk({nm, "_tile"}, input_data, 0);
        chk({nm, "_wt"}, select_weight, 0);
`ifdef DWCONV_FETCH_PERF_EN
        chk({nm, "_perf"}, perf_cycles, 0);
`endif
    endtask

    task automatic chk_pass_totals(input string nm);
        chk({nm, "_en_count"}, n_en, 288);
        chk({nm, "_busy_cycles"}, busy_cnt, 1728);
        chk({nm, "_done_count"}, done_cnt, 1);
        chk({nm, "_start_to_done"}, done_cyc - start_cyc, 1729);
        chk({nm, "_done_after_last_en"}, done_cyc - last_cyc, 1);
        chk({nm, "_idle_after"}, {busy, done, en}, 0);
`ifdef DWCONV_FETCH_PERF_EN
        chk({nm, "_perf"}, perf_cycles, 1729);
`endif
    endtask

    typedef struct {
        int         pos;
        int         ch;
        int         r;
        int         c;
        logic [7:0] exp;
    } vec_t;

    localparam int NV = 26;
    vec_t tv [NV];

    initial begin
        logic [127:0] t;
        int d0;

        // Channel c pixel(r,col) = 4c + 10r + col; channel 31 is all 0x7F. Kernel tap i = 9c + i + 1.
        tv[0]  = '{0, 0, 0, 0, 8'd0};    tv[1]  = '{0, 0, 0, 3, 8'd0};
        tv[2]  = '{0, 0, 3, 0, 8'd0};    tv[3]  = '{0, 0, 1, 1, 8'd0};
        tv[4]  = '{0, 0, 1, 2, 8'd1};    tv[5]  = '{0, 0, 2, 1, 8'd10};
        tv[6]  = '{0, 0, 3, 3, 8'd22};   tv[7]  = '{4, 0, 0, 0, 8'd11};
        tv[8]  = '{4, 0, 3, 3, 8'd44};   tv[9]  = '{4, 0, 0, 3, 8'd14};
        tv[10] = '{4, 0, 2, 1, 8'd32};   tv[11] = '{8, 31, 3, 3, 8'h00};
        tv[12] = '{8, 31, 3, 0, 8'h00};  tv[13] = '{8, 31, 0, 3, 8'h00};
        tv[14] = '{8, 31, 0, 0, 8'h7F};  tv[15] = '{8, 31, 2, 2, 8'h7F};
        tv[16] = '{2, 0, 1, 3, 8'd0};    tv[17] = '{2, 0, 1, 2, 8'd5};
        tv[18] = '{2, 0, 2, 0, 8'd13};   tv[19] = '{6, 0, 0, 1, 8'd30};
        tv[20] = '{6, 0, 2, 2, 8'd51};   tv[21] = '{6, 0, 3, 1, 8'd0};
        tv[22] = '{4, 5, 0, 0, 8'd31};   tv[23] = '{4, 5, 3, 3, 8'd64};
        tv[24] = '{8, 30, 2, 2, 8'd175}; tv[25] = '{8, 30, 0, 0, 8'd153};

        for (int a = 0; a < 256; a++) fm[a] = '0;
        for (int ch = 0; ch < 32; ch++) begin
            for (int r = 0; r < 6; r++)
                for (int c = 0; c < 6; c++)
                    fm[ch*8 + r][c*8 +: 8] = (ch == 31) ? 8'h7F : 8'(ch*4 + 10*r + c);
            for (int i = 0; i < 9; i++) wt[ch][i*8 +: 8] = 8'(ch*9 + i + 1);
        end

        repeat (3) @(negedge clk);
        chk_idle_outputs("reset");
        rst_b = 1'b1;
        @(negedge clk);

        // Pass 1: full layer.
        start_monitor();
        pulse_start();
        wait_done("pass1_done_seen");
        repeat (2) @(negedge clk);
        mon_on = 1'b0;
        chk_pass_totals("pass1");
        chk("hold_tile_after_done", input_data, 128'h00000000_007F7F7F_007F7F7F_007F7F7F);
        chk("hold_cnt_pos_after_done", {cnt_out, pos_out}, {5'd31, 4'd8});

        for (int i = 0; i < NV; i++) begin
            t = cap_tile[tv[i].pos*32 + tv[i].ch];
            chk($sformatf("tile_p%0d_c%0d_e%0d%0d", tv[i].pos, tv[i].ch, tv[i].r, tv[i].c),
                t[(tv[i].r*4 + tv[i].c)*8 +: 8], tv[i].exp);
        end
        chk("tile_p0_c0_full", cap_tile[0], 128'h16151400_0C0B0A00_02010000_00000000);
        chk("tile_p8_c31_full", cap_tile[8*32 + 31], 128'h00000000_007F7F7F_007F7F7F_007F7F7F);
        chk("wt_p0_c0", cap_w[0], 72'h090807060504030201);
        chk("wt_p4_c5", cap_w[4*32 + 5], 72'h363534333231302F2E);
        chk("wt_p8_c31", cap_w[8*32 + 31], 72'h201F1E1D1C1B1A1918);

        // Pass 2: extra start at tile 5 is ignored, then async reset during tile 100.
        start_monitor();
        pulse_start();
`ifdef DWCONV_FETCH_PERF_EN
        chk("perf_cleared_on_start", perf_cycles, 0);
`endif
        for (int k = 0; k < 2000 && n_en < 5; k++) @(negedge clk);
        chk("reach_tile5", n_en >= 5, 1'b1);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("busy_after_extra_start", busy, 1'b1);
        for (int k = 0; k < 2000 && n_en < 100; k++) @(negedge clk);
        chk("reach_tile100", n_en >= 100, 1'b1);
        repeat (2) @(negedge clk);
        d0 = done_total;
        mon_on = 1'b0;
        #2 rst_b = 1'b0;
        #1 chk_idle_outputs("midpass_reset");
        repeat (3) @(negedge clk);
        rst_b = 1'b1;
        repeat (10) @(negedge clk);
        chk("no_done_after_reset", done_total, d0);
        chk("idle_after_reset", {busy, en, fmap_rd_en, w_rd_en}, 0);

        // Pass 3: fresh start from cnt=0, pos=0.
        start_monitor();
        pulse_start();
        wait_done("pass3_done_seen");
        repeat (2) @(negedge clk);
        mon_on = 1'b0;
        chk_pass_totals("pass3");
        chk("pass3_first_tile", cap_tile[0], 128'h16151400_0C0B0A00_02010000_00000000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
